// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an external W-bit parallel/serial shift register.
// Each command parallel-loads a value and then shifts it a given number of times.
// The shift can be logical, arithmetic, rotate or external-serial fill, in either direction.
// Rotate and sign-extension fill bits come back from the register's own output bus.
module shift_sequencer #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  cmd_data,
    input  logic [AW-1:0] cmd_amount,
    input  logic          cmd_dir,
    input  logic [1:0]    cmd_mode,
    input  logic          ser_in,
    input  logic [W-1:0]  sr_q,
    output logic [W-1:0]  sr_a,
    output logic          sr_psselect,
    output logic          sr_rlselect,
    output logic          sr_sileft,
    output logic          sr_siright,
    output logic          sr_enb,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  data_r;
    logic [AW-1:0] amount_r;
    logic [AW-1:0] count_r;
    logic          dir_r;
    logic [1:0]    mode_r;
    logic          fill_right;
    logic          fill_left;

    // State register, command capture in IDLE and the shift down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_r   <= '0;
            amount_r <= '0;
            count_r  <= '0;
            dir_r    <= 1'b0;
            mode_r   <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_r   <= cmd_data;
                        amount_r <= cmd_amount;
                        dir_r    <= cmd_dir;
                        mode_r   <= cmd_mode;
                    end
                end
                LOAD:    count_r <= amount_r;
                SHIFT:   count_r <= count_r - AW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state decode; a zero amount skips SHIFT entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = (amount_r != '0) ? SHIFT : DONE;
            SHIFT:   if (count_r == AW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fill bit selection closes the rotate and sign-extension loop through sr_q
    always_comb begin
        fill_right = 1'b0;
        fill_left  = 1'b0;
        case (mode_r)
            MODE_LOGICAL: begin
                fill_right = 1'b0;
                fill_left  = 1'b0;
            end
            MODE_ARITH: begin
                fill_right = sr_q[W-1];
                fill_left  = 1'b0;
            end
            MODE_ROTATE: begin
                fill_right = sr_q[0];
                fill_left  = sr_q[W-1];
            end
            default: begin
                fill_right = ser_in;
                fill_left  = ser_in;
            end
        endcase
    end

    // Moore control outputs from the registered state and command fields
    always_comb begin
        sr_a        = '0;
        sr_psselect = 1'b0;
        sr_rlselect = 1'b0;
        sr_sileft   = 1'b0;
        sr_siright  = 1'b0;
        sr_enb      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            LOAD: begin
                sr_enb      = 1'b1;
                sr_psselect = 1'b1;
                sr_a        = data_r;
                busy        = 1'b1;
            end
            SHIFT: begin
                sr_enb      = 1'b1;
                sr_rlselect = dir_r;
                busy        = 1'b1;
                if (dir_r) begin
                    sr_sileft = fill_right;
                end else begin
                    sr_siright = fill_left;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign result = sr_q;

endmodule
